// File: rtl/mips32_loader.sv
`default_nettype none
// ============================================================================
//  Module      : mips32_loader
//  Description : Boot-time program loader for the mips32 core. Frames a
//                big-endian byte stream (base, count, payload, checksum) into
//                32-bit words, writes them through a dedicated memory write
//                port and releases the core once the XOR checksum matches.
//                Re-arms for a new image when the core reports a halt.
//  Ports       : clk1        - system clock (posedge)
//                rst_n       - asynchronous active-low reset
//                in_valid    - input byte valid
//                in_data     - input byte
//                in_ready    - loader accepts a byte this cycle (registered)
//                mem_we      - one-cycle write strobe per word
//                mem_addr    - memory word address
//                mem_wdata   - memory write data
//                cpu_run     - core release; core holds pc while low
//                cpu_halted  - core halted flag
//                done        - image loaded and verified
//                err         - sticky error flag
//  Revision    : 1.0 - initial release
// ============================================================================
module mips32_loader #(
    parameter int ADDR_W = 10,
    parameter int CNT_W  = 16
) (
    input  logic              clk1,
    input  logic              rst_n,
    input  logic              in_valid,
    input  logic [7:0]        in_data,
    output logic              in_ready,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [31:0]       mem_wdata,
    output logic              cpu_run,
    input  logic              cpu_halted,
    output logic              done,
    output logic              err
);

    typedef enum logic [2:0] {
        S_HDR  = 3'd0,
        S_DATA = 3'd1,
        S_CHK  = 3'd2,
        S_RUN  = 3'd3,
        S_ERR  = 3'd4
    } state_t;

    // Number of addressable words; 17 bits so ADDR_W up to 16 still fits.
    localparam logic [16:0] MEM_WORDS = 17'd1 << ADDR_W;

    state_t              state_q,     state_d;
    logic [1:0]          byte_cnt_q,  byte_cnt_d;
    logic [23:0]         shift_q,     shift_d;
    logic [ADDR_W-1:0]   base_q,      base_d;
    logic [CNT_W-1:0]    cnt_q,       cnt_d;
    logic [CNT_W-1:0]    idx_q,       idx_d;
    logic [7:0]          xor_q,       xor_d;
    logic                run_arm_q,   run_arm_d;
    logic                in_ready_q,  in_ready_d;
    logic                mem_we_q,    mem_we_d;
    logic [ADDR_W-1:0]   mem_addr_q,  mem_addr_d;
    logic [31:0]         mem_wdata_q, mem_wdata_d;
    logic                cpu_run_q,   cpu_run_d;
    logic                done_q,      done_d;
    logic                err_q,       err_d;

    logic                w_xfer;
    logic [31:0]         w_word;
    logic [16:0]         w_end;
    logic                w_hdr_ok;

    assign w_xfer = in_valid && in_ready_q;
    // Current byte completes either the header (base,count) or a payload word.
    assign w_word = {shift_q, in_data};
    // base + N must not run past the top of memory; base itself must fit.
    assign w_end    = {1'b0, w_word[31:16]} + {1'b0, w_word[15:0]};
    assign w_hdr_ok = ({1'b0, w_word[31:16]} < MEM_WORDS) && (w_end <= MEM_WORDS);

    always_comb begin
        state_d     = state_q;
        byte_cnt_d  = byte_cnt_q;
        shift_d     = shift_q;
        base_d      = base_q;
        cnt_d       = cnt_q;
        idx_d       = idx_q;
        xor_d       = xor_q;
        run_arm_d   = run_arm_q;
        mem_we_d    = 1'b0;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;

        case (state_q)
            S_HDR: begin
                if (w_xfer) begin
                    shift_d    = {shift_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    if (byte_cnt_q == 2'd3) begin
                        base_d = w_word[16 +: ADDR_W];
                        cnt_d  = CNT_W'(w_word[15:0]);
                        idx_d  = '0;
                        xor_d  = 8'h00;
                        if (!w_hdr_ok)
                            state_d = S_ERR;
                        else if (w_word[15:0] == 16'd0)
                            state_d = S_CHK;
                        else
                            state_d = S_DATA;
                    end
                end
            end

            S_DATA: begin
                if (w_xfer) begin
                    shift_d    = {shift_q[15:0], in_data};
                    byte_cnt_d = byte_cnt_q + 2'd1;
                    xor_d      = xor_q ^ in_data;
                    // Write is registered, so the strobe appears the cycle
                    // after the last byte while input keeps flowing.
                    if (byte_cnt_q == 2'd3) begin
                        mem_we_d    = 1'b1;
                        mem_addr_d  = base_q + idx_q[ADDR_W-1:0];
                        mem_wdata_d = w_word;
                        idx_d       = idx_q + CNT_W'(1);
                        if (idx_q == cnt_q - CNT_W'(1))
                            state_d = S_CHK;
                    end
                end
            end

            S_CHK: begin
                if (w_xfer) begin
                    run_arm_d = 1'b0;
                    state_d   = (in_data == xor_q) ? S_RUN : S_ERR;
                end
            end

            S_RUN: begin
                // First RUN cycle only arms the halt detect, so a stale
                // halted flag from the previous program is not taken.
                run_arm_d = 1'b1;
                if (run_arm_q && cpu_halted) begin
                    state_d    = S_HDR;
                    byte_cnt_d = 2'd0;
                end
            end

            S_ERR: begin
                state_d = S_ERR;
            end

            default: begin
                state_d = S_ERR;
            end
        endcase

        in_ready_d = (state_d == S_HDR) || (state_d == S_DATA) || (state_d == S_CHK);
        cpu_run_d  = (state_d == S_RUN);
        done_d     = (state_d == S_RUN);
        err_d      = err_q || (state_d == S_ERR);
    end

    always_ff @(posedge clk1 or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_HDR;
            byte_cnt_q  <= 2'd0;
            shift_q     <= 24'd0;
            base_q      <= '0;
            cnt_q       <= '0;
            idx_q       <= '0;
            xor_q       <= 8'h00;
            run_arm_q   <= 1'b0;
            in_ready_q  <= 1'b0;
            mem_we_q    <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= 32'd0;
            cpu_run_q   <= 1'b0;
            done_q      <= 1'b0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            byte_cnt_q  <= byte_cnt_d;
            shift_q     <= shift_d;
            base_q      <= base_d;
            cnt_q       <= cnt_d;
            idx_q       <= idx_d;
            xor_q       <= xor_d;
            run_arm_q   <= run_arm_d;
            in_ready_q  <= in_ready_d;
            mem_we_q    <= mem_we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            cpu_run_q   <= cpu_run_d;
            done_q      <= done_d;
            err_q       <= err_d;
        end
    end

    assign in_ready  = in_ready_q;
    assign mem_we    = mem_we_q;
    assign mem_addr  = mem_addr_q;
    assign mem_wdata = mem_wdata_q;
    assign cpu_run   = cpu_run_q;
    assign done      = done_q;
    assign err       = err_q;

endmodule
`default_nettype wire

// File: tb/tb_mips32_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_mips32_loader
//  Description : Self-checking bench for mips32_loader. Table of image
//                vectors plus hand sequences for mid-frame reset and the
//                halt / re-arm path.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_mips32_loader;

    localparam int ADDR_W = 10;
    localparam int CNT_W  = 16;

    logic              clk1 = 1'b0;
    logic              rst_n = 1'b0;
    logic              in_valid = 1'b0;
    logic [7:0]        in_data = 8'h00;
    logic              cpu_halted = 1'b0;
    logic              in_ready;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [31:0]       mem_wdata;
    logic              cpu_run;
    logic              done;
    logic              err;

    mips32_loader #(.ADDR_W(ADDR_W), .CNT_W(CNT_W)) dut (
        .clk1       (clk1),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_data    (in_data),
        .in_ready   (in_ready),
        .mem_we     (mem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .cpu_run    (cpu_run),
        .cpu_halted (cpu_halted),
        .done       (done),
        .err        (err)
    );

    always #5 clk1 = ~clk1;

    int errors = 0;
    int checks = 0;
    int stalls = 0;
    int timeouts = 0;
    int viol = 0;

    logic [ADDR_W-1:0] wa[$];
    logic [31:0]       wd[$];

    // addi r1,r0,120 ; lw r2,0(r1) ; addi r2,r2,45 ; sw r2,1(r1) ;
    // addi r3,r0,1 ; addi r4,r0,2 ; addi r5,r0,3 ; hlt
    logic [31:0] prog [8] = '{32'h20010078, 32'h8C220000, 32'h2042002D, 32'hAC220001,
                              32'h20030001, 32'h20040002, 32'h20050003, 32'hFC000000};

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Write monitor, sampled mid-cycle.
    always @(negedge clk1) begin
        if (mem_we === 1'b1) begin
            wa.push_back(mem_addr);
            wd.push_back(mem_wdata);
            if (cpu_run !== 1'b0) viol++;
        end
    end

    task automatic do_reset();
        in_valid   = 1'b0;
        cpu_halted = 1'b0;
        #2 rst_n = 1'b0;
        repeat (2) @(posedge clk1);
        #1;
        wa.delete();
        wd.delete();
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b, input bit gaps, input bit payload);
        int t;
        if (gaps) begin
            int g;
            g = $urandom_range(0, 2);
            repeat (g) begin
                in_valid = 1'b0;
                @(posedge clk1);
                #1;
            end
        end
        in_valid = 1'b1;
        in_data  = b;
        if (payload && in_ready !== 1'b1) stalls++;
        t = 0;
        while (in_ready !== 1'b1 && t < 50) begin
            @(posedge clk1);
            #1;
            t++;
        end
        if (t >= 50) begin
            timeouts++;
            in_valid = 1'b0;
            return;
        end
        @(posedge clk1);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic send_image(input int base, input int n, input logic [7:0] mask,
                              input bit gaps, input bit hdr_only, input int nbytes_cut);
        logic [15:0] b16;
        logic [15:0] n16;
        logic [31:0] w;
        logic [7:0]  x;
        int          sent;
        b16 = 16'(base);
        n16 = 16'(n);
        x = 8'h00;
        sent = 0;
        send_byte(b16[15:8], gaps, 1'b0);
        send_byte(b16[7:0],  gaps, 1'b0);
        send_byte(n16[15:8], gaps, 1'b0);
        send_byte(n16[7:0],  gaps, 1'b0);
        if (hdr_only) return;
        for (int i = 0; i < n; i++) begin
            w = prog[i % 8];
            for (int j = 0; j < 4; j++) begin
                if (nbytes_cut >= 0 && sent == nbytes_cut) return;
                send_byte(w[31-8*j -: 8], gaps, 1'b1);
                x = x ^ w[31-8*j -: 8];
                sent++;
            end
        end
        send_byte(x ^ mask, gaps, 1'b0);
    endtask

    task automatic check_writes(input string tag, input int base, input int n);
        check({tag, "_nwrites"}, 32'(wa.size()), 32'(n));
        for (int i = 0; i < n && i < wa.size(); i++) begin
            check($sformatf("%s_addr%0d", tag, i), 32'(wa[i]), 32'(base + i));
            check($sformatf("%s_data%0d", tag, i), wd[i], prog[i % 8]);
        end
    endtask

    typedef struct {
        string      name;
        int         base;
        int         n;
        logic [7:0] mask;
        bit         gaps;
        bit         hdr_only;
        int         exp_writes;
        bit         exp_done;
        bit         exp_err;
    } vec_t;

    vec_t vecs [7];

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{"good_b2b",    0,    8, 8'h00, 1'b0, 1'b0, 8, 1'b1, 1'b0};
        vecs[1] = '{"bad_csum",    0,    8, 8'h01, 1'b0, 1'b0, 8, 1'b0, 1'b1};
        vecs[2] = '{"hdr_ovf",     1020, 8, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1};
        vecs[3] = '{"n_zero",      0,    0, 8'h00, 1'b0, 1'b0, 0, 1'b1, 1'b0};
        vecs[4] = '{"good_gaps",   0,    8, 8'h00, 1'b1, 1'b0, 8, 1'b1, 1'b0};
        vecs[5] = '{"top_fit",     1016, 8, 8'h00, 1'b1, 1'b0, 8, 1'b1, 1'b0};
        vecs[6] = '{"base_oob",    1024, 0, 8'h00, 1'b0, 1'b1, 0, 1'b0, 1'b1};

        // Reset values while reset is held.
        #1;
        check("rst_in_ready",  32'(in_ready),  0);
        check("rst_mem_we",    32'(mem_we),    0);
        check("rst_mem_addr",  32'(mem_addr),  0);
        check("rst_mem_wdata", mem_wdata,      0);
        check("rst_cpu_run",   32'(cpu_run),   0);
        check("rst_done",      32'(done),      0);
        check("rst_err",       32'(err),       0);

        for (int v = 0; v < 7; v++) begin
            do_reset();
            check({vecs[v].name, "_ready_after_rst"}, 32'(in_ready), 1);
            stalls = 0;
            timeouts = 0;
            send_image(vecs[v].base, vecs[v].n, vecs[v].mask, vecs[v].gaps, vecs[v].hdr_only, -1);
            // Immediately after the final accepted byte.
            check({vecs[v].name, "_run_next"}, 32'(cpu_run), 32'(vecs[v].exp_done));
            check({vecs[v].name, "_err_next"}, 32'(err),     32'(vecs[v].exp_err));
            check({vecs[v].name, "_rdy_next"}, 32'(in_ready), 0);
            repeat (3) @(posedge clk1);
            #1;
            check_writes(vecs[v].name, vecs[v].base, vecs[v].exp_writes);
            check({vecs[v].name, "_done"},    32'(done),     32'(vecs[v].exp_done));
            check({vecs[v].name, "_cpu_run"}, 32'(cpu_run),  32'(vecs[v].exp_done));
            check({vecs[v].name, "_err"},     32'(err),      32'(vecs[v].exp_err));
            check({vecs[v].name, "_in_ready"}, 32'(in_ready), 0);
            check({vecs[v].name, "_stalls"},  32'(stalls),   0);
            check({vecs[v].name, "_timeouts"}, 32'(timeouts), 0);
        end

        // Asynchronous reset in the middle of the second word.
        do_reset();
        timeouts = 0;
        send_image(0, 8, 8'h00, 1'b0, 1'b0, 6);
        #2;
        check("mid_pre_wdata", mem_wdata, prog[0]);
        rst_n = 1'b0;
        #1;
        check("mid_rst_in_ready",  32'(in_ready), 0);
        check("mid_rst_mem_we",    32'(mem_we),   0);
        check("mid_rst_mem_wdata", mem_wdata,     0);
        check("mid_rst_mem_addr",  32'(mem_addr), 0);
        check("mid_rst_cpu_run",   32'(cpu_run),  0);
        #3;
        rst_n = 1'b1;
        @(posedge clk1);
        #1;
        wa.delete();
        wd.delete();
        send_image(0, 8, 8'h00, 1'b0, 1'b0, -1);
        check("reload_run", 32'(cpu_run), 1);
        check_writes("reload", 0, 8);

        // Halt: ignored in the first RUN cycle, honoured afterwards.
        cpu_halted = 1'b1;
        @(posedge clk1);
        #1;
        check("halt_ignored_first", 32'(cpu_run), 1);
        @(posedge clk1);
        #1;
        check("halt_cpu_run", 32'(cpu_run), 0);
        check("halt_done",    32'(done),    0);
        check("halt_err",     32'(err),     0);
        check("halt_ready",   32'(in_ready), 1);
        cpu_halted = 1'b0;
        wa.delete();
        wd.delete();
        send_image(100, 3, 8'h00, 1'b1, 1'b0, -1);
        repeat (2) @(posedge clk1);
        #1;
        check_writes("second", 100, 3);
        check("second_done", 32'(done), 1);
        check("mid_timeouts", 32'(timeouts), 0);
        check("we_while_run", 32'(viol), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
